// File: rtl/window_gen.sv
// window_gen: sliding KERNEL_HEIGHT x KERNEL_WIDTH window over a raster pixel stream.
// Define WINGEN_WIN_IDX_EN to add win_row/win_col top-left window coordinates.
module window_gen #(
  parameter int INWIDTH       = 8,
  parameter int KERNEL_WIDTH  = 4,
  parameter int KERNEL_HEIGHT = 3,
  parameter int IMG_WIDTH     = 16,
  parameter int IMG_HEIGHT    = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [INWIDTH-1:0]                            pix_in,
  input  logic                                          pix_valid,
  output logic                                          pix_ready,
  output logic [KERNEL_WIDTH*KERNEL_HEIGHT*INWIDTH-1:0] X,
  output logic                                          start,
  input  logic                                          done,
  output logic                                          frame_done
`ifdef WINGEN_WIN_IDX_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0]                 win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]                  win_col
`endif
);

  localparam int KW  = KERNEL_WIDTH;
  localparam int KH  = KERNEL_HEIGHT;
  localparam int CW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int NLB = (KH > 1) ? KH - 1 : 1;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [INWIDTH-1:0] r_lb  [NLB][IMG_WIDTH];
  logic [INWIDTH-1:0] r_win [KH][KW];
  logic [INWIDTH-1:0] w_newcol [KH];

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_last;
  logic          r_frame_done;

  logic w_xfer;
  logic w_col_end;
  logic w_row_end;
  logic w_win_ok;
  logic w_win_done;

  assign w_xfer     = pix_valid && pix_ready;
  assign w_col_end  = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_end  = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_win_ok   = (r_row >= RW'(KH - 1)) &&
                      (r_col >= CW'(KW - 1));
  assign w_win_done = w_xfer && w_win_ok;

  // Incoming column: buffered rows oldest-first, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < KH - 1; r++) begin
      w_newcol[r] = r_lb[r][r_col];
    end
    w_newcol[KH-1] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      for (int k = 0; k < KH - 2; k++) begin
        r_lb[k][r_col] <= r_lb[k+1][r_col];
      end
      r_lb[NLB-1][r_col] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win <= '{default: '0};
    end else if (w_xfer) begin
      for (int r = 0; r < KH; r++) begin
        for (int c = 0; c < KW - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][KW-1] <= w_newcol[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_win_done) begin
        r_last <= w_col_end && w_row_end;
      end
      r_frame_done <= (r_state == S_WAIT) && done && r_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == S_LOAD): if (w_win_done) w_next = S_WAIT;
      (r_state == S_WAIT): if (done)       w_next = S_LOAD;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    start     = 1'b0;
    unique case (1'b1)
      (r_state == S_LOAD): pix_ready = 1'b1;
      (r_state == S_WAIT): start     = 1'b1;
    endcase
  end

  // Top-left element lands in the MSBs.
  always_comb begin
    X = '0;
    for (int r = 0; r < KH; r++) begin
      for (int c = 0; c < KW; c++) begin
        X[(KH*KW-1-(r*KW+c))*INWIDTH +: INWIDTH] = r_win[r][c];
      end
    end
  end

  assign frame_done = r_frame_done;

`ifdef WINGEN_WIN_IDX_EN
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_row <= '0;
      r_win_col <= '0;
    end else if (w_win_done) begin
      r_win_row <= r_row - RW'(KH - 1);
      r_win_col <= r_col - CW'(KW - 1);
    end
  end

  assign win_row = r_win_row;
  assign win_col = r_win_col;
`endif

endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: randomized scoreboard bench for window_gen.
// Reference model stores the whole frame and cuts each window from it.
`timescale 1ns/1ps
module tb_window_gen;

  localparam int W    = 8;
  localparam int KW   = 4;
  localparam int KH   = 3;
  localparam int IW   = 16;
  localparam int IH   = 8;
  localparam int XW   = KW*KH*W;
  localparam int NWIN = (IW-KW+1)*(IH-KH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic          done = 1'b0;
  logic [W-1:0]  pix_in = '0;
  logic          pix_ready;
  logic          start;
  logic          frame_done;
  logic [XW-1:0] X;
`ifdef WINGEN_WIN_IDX_EN
  logic [$clog2(IH)-1:0] win_row;
  logic [$clog2(IW)-1:0] win_col;
`endif

  always #5 clk = ~clk;

  window_gen #(
    .INWIDTH(W), .KERNEL_WIDTH(KW), .KERNEL_HEIGHT(KH),
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk(clk), .reset(reset),
    .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .X(X),
    .start(start), .done(done),
    .frame_done(frame_done)
`ifdef WINGEN_WIN_IDX_EN
    , .win_row(win_row), .win_col(win_col)
`endif
  );

  typedef struct {
    logic [XW-1:0] x;
    int            row;
    int            col;
    bit            last;
  } exp_t;

  exp_t          q[$];
  exp_t          cur;
  exp_t          m_e;
  int            total = 0;
  int            bad = 0;
  logic [W-1:0]  img [IH][IW];
  int            m_row = 0;
  int            m_col = 0;
  int            n_xfer = 0;
  int            n_start = 0;
  int            n_fd = 0;
  int            first_xfer = -1;
  logic [XW-1:0] first_x = '0;
  bit            acc_last = 1'b0;
  bit            prev_start = 1'b0;
  int            s_len = 0;
  int            resp_dly = 1;
  bit            spurious = 1'b0;
  int            drv_col = 0;

  task automatic chk_x(input string nm, input logic [XW-1:0] act,
                       input logic [XW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model: whole-frame image, windows cut by coordinates.
  always @(posedge clk) begin
    if (reset) begin
      m_row  = 0;
      m_col  = 0;
      n_xfer = 0;
    end else if (pix_valid && pix_ready) begin
      img[m_row][m_col] = pix_in;
      n_xfer++;
      if (m_row >= KH-1 && m_col >= KW-1) begin
        m_e.row  = m_row - KH + 1;
        m_e.col  = m_col - KW + 1;
        m_e.last = (m_row == IH-1) && (m_col == IW-1);
        m_e.x    = '0;
        for (int r = 0; r < KH; r++)
          for (int c = 0; c < KW; c++)
            m_e.x[(KH*KW-1-(r*KW+c))*W +: W] =
              img[m_e.row+r][m_e.col+c];
        q.push_back(m_e);
      end
      m_col++;
      if (m_col == IW) begin
        m_col = 0;
        m_row = (m_row + 1) % IH;
      end
    end
  end

  // frame_done is expected the cycle after done retires the last window.
  always @(posedge clk) begin
    acc_last = !reset && start && done && cur.last;
  end

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      prev_start = 1'b0;
      first_xfer = -1;
      s_len      = 0;
    end else begin
      chk_i("frame_done", int'(frame_done), int'(acc_last));
      if (frame_done) n_fd++;
      if (start && !prev_start) begin
        s_len = 0;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: got start=1 want no window");
        end else begin
          cur = q.pop_front();
          chk_x("window_x", X, cur.x);
`ifdef WINGEN_WIN_IDX_EN
          chk_i("win_row", int'(win_row), cur.row);
          chk_i("win_col", int'(win_col), cur.col);
`endif
          n_start++;
          if (first_xfer < 0) begin
            first_xfer = n_xfer;
            first_x    = X;
          end
        end
      end
      if (start) begin
        s_len++;
        chk_x("hold_x", X, cur.x);
        chk_i("ready_in_wait", int'(pix_ready), 0);
      end
      if (!start && prev_start && resp_dly >= 0)
        chk_i("wait_len", s_len, resp_dly + 1);
      prev_start = start;
    end
  end

  // Downstream responder: done after a programmed or random delay.
  initial begin
    int wcnt;
    int dly;
    wcnt = 0;
    dly  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (start && !reset) begin
        done = (wcnt == dly);
        wcnt++;
      end else begin
        wcnt = 0;
        dly  = (resp_dly >= 0) ? resp_dly : int'($urandom_range(0, 5));
        done = spurious && ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic send(input int n, input bit ramp, input int vpct);
    int sent;
    int stall;
    bit go;
    sent  = 0;
    stall = 0;
    while (sent < n) begin
      pix_valid = ($urandom_range(0, 99) < vpct);
      pix_in    = ramp ? W'(drv_col + 1) : W'($urandom);
      go        = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      if (go) begin
        sent++;
        drv_col = (drv_col + 1) % IW;
        stall   = 0;
      end else if (++stall > 200) begin
        total++;
        bad++;
        $display("FAIL stall: got no transfer in 200 cycles want transfer");
        summary();
        $finish;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    int f0;
    do_reset();
    chk_i("rst_start", int'(start), 0);
    chk_i("rst_frame_done", int'(frame_done), 0);
    chk_x("rst_x", X, '0);
    chk_i("rst_ready", int'(pix_ready), 1);
    reset   = 1'b0;
    drv_col = 0;

    // Ramp frame, done one cycle after start
    resp_dly = 1;
    spurious = 1'b0;
    s0 = n_start;
    f0 = n_fd;
    send(IW*IH, 1'b1, 100);
    idle(20);
    chk_i("first_xfer", first_xfer, 36);
    chk_x("first_x", first_x, 96'h010203040102030401020304);
    chk_i("starts_f1", n_start - s0, NWIN);
    chk_i("fd_f1", n_fd - f0, 1);

    // Long done latency with pix_valid held high
    resp_dly = 5;
    s0 = n_start;
    f0 = n_fd;
    send(IW*IH, 1'b0, 100);
    idle(20);
    chk_i("starts_f2", n_start - s0, NWIN);
    chk_i("fd_f2", n_fd - f0, 1);

    // Random valid gaps, random latency, stray done in LOAD
    resp_dly = -1;
    spurious = 1'b1;
    s0 = n_start;
    f0 = n_fd;
    send(IW*IH, 1'b0, 70);
    idle(20);
    chk_i("starts_f3", n_start - s0, NWIN);
    chk_i("fd_f3", n_fd - f0, 1);

    // Abandon a frame after 50 transfers
    send(50, 1'b0, 80);
    do_reset();
    reset   = 1'b0;
    drv_col = 0;
    s0 = n_start;
    f0 = n_fd;
    send(35, 1'b0, 100);
    idle(10);
    chk_i("no_start_35", n_start - s0, 0);
    send(1, 1'b0, 100);
    idle(10);
    chk_i("first_xfer_rst", first_xfer, 36);
    send(IW*IH - 36, 1'b0, 75);
    idle(20);
    chk_i("starts_f4", n_start - s0, NWIN);
    chk_i("fd_f4", n_fd - f0, 1);
    chk_i("queue_empty", q.size(), 0);

    summary();
    $finish;
  end

endmodule
